alpha_pixel_shifter: RTL and testbench

Serialises alphanumeric character cells for the VDG alpha path. Latches the character byte fetched from video RAM and drives the 6-bit character code and glyph row to the alpha character ROM. Loads the returned 8-bit row into a shift register and shifts one pixel out per pixel-clock enable. Sits between the display address/fetch sequencer (upstream) and the colour/output mixer (downstream); the ROM is a combinational side-lookup.

---
 rtl/alpha_pixel_shifter.sv | 108 ++++++++++
 tb/tb_alpha_pixel_shifter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alpha_pixel_shifter.sv
// Alpha-mode character serialiser: latches the VRAM character byte, addresses the
// glyph ROM and shifts the returned row out one pixel per pixel-clock enable.
module alpha_pixel_shifter #(
   parameter int unsigned GLYPH_TOP = 3,
   parameter int unsigned CELL_ROWS = 12
) (
   input  logic       Clk,
   input  logic       nReset,
   input  logic       PixEn,
   input  logic       HActive,
   input  logic       LineStart,
   input  logic       FieldStart,
   input  logic [7:0] VData,
   input  logic       VStrobe,
   input  logic       Css,
   input  logic [7:0] RomData,
   output logic [5:0] CharCode,
   output logic [3:0] RomRow,
   output logic       FetchReq,
   output logic       PixOut,
   output logic       CssOut,
   output logic       Underrun
);

   localparam int unsigned ROW_W   = 4;
   localparam int unsigned PIX_W   = 3;
   localparam int unsigned PX_W    = 8;
   localparam int unsigned GLYPH_H = 7;

   logic [ROW_W-1:0] row_cnt;
   logic [PIX_W-1:0] pix_cnt;
   logic [6:0]       char_latch;
   logic             valid;
   logic [PX_W-1:0]  shift_reg;

   logic             in_band_c;
   logic             step_c;
   logic             load_c;
   logic [PX_W-1:0]  base_c;
   logic [PX_W-1:0]  glyph_c;
   logic             unused_vdata_c;

   assign unused_vdata_c = VData[7];

   // Glyph band decode and ROM addressing
   always_comb begin
      in_band_c = (row_cnt >= ROW_W'(GLYPH_TOP)) &&
                  (row_cnt <= ROW_W'(GLYPH_TOP + GLYPH_H - 1));
      RomRow    = in_band_c ? (row_cnt - ROW_W'(GLYPH_TOP)) : '0;
      CharCode  = char_latch[5:0];
      step_c    = PixEn && HActive;
      load_c    = step_c && (pix_cnt == '0);
      base_c    = in_band_c ? RomData : '0;
      glyph_c   = valid ? (base_c ^ {PX_W{char_latch[6]}}) : '0;
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         row_cnt    <= '0;
         pix_cnt    <= '0;
         char_latch <= '0;
         valid      <= 1'b0;
         shift_reg  <= '0;
         PixOut     <= 1'b0;
         CssOut     <= 1'b0;
         FetchReq   <= 1'b0;
         Underrun   <= 1'b0;
      end else begin
         // Field start overrides the per-line row advance
         if (FieldStart)
            row_cnt <= '0;
         else if (LineStart)
            row_cnt <= (row_cnt == ROW_W'(CELL_ROWS - 1)) ? '0 : row_cnt + ROW_W'(1);

         if (LineStart)
            pix_cnt <= '0;
         else if (step_c)
            pix_cnt <= pix_cnt + PIX_W'(1);

         FetchReq <= LineStart || load_c;

         if (load_c) begin
            PixOut    <= glyph_c[PX_W-1];
            shift_reg <= glyph_c << 1;
            CssOut    <= Css;
         end else if (step_c) begin
            PixOut    <= shift_reg[PX_W-1];
            shift_reg <= shift_reg << 1;
         end else if (PixEn) begin
            PixOut    <= 1'b0;
         end

         // A strobe coinciding with a load refills the latch after the load used it
         if (VStrobe) begin
            char_latch <= VData[6:0];
            valid      <= 1'b1;
         end else if (load_c) begin
            valid      <= 1'b0;
         end

         if (FieldStart)
            Underrun <= 1'b0;
         else if (load_c && !valid)
            Underrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_alpha_pixel_shifter.sv
// Self-checking bench for alpha_pixel_shifter: directed scenarios plus randomized
// lines checked against a cell-level reference model.
module tb_alpha_pixel_shifter;

   logic       Clk;
   logic       nReset;
   logic       PixEn;
   logic       HActive;
   logic       LineStart;
   logic       FieldStart;
   logic [7:0] VData;
   logic       VStrobe;
   logic       Css;
   logic [7:0] RomData;
   logic [5:0] CharCode;
   logic [3:0] RomRow;
   logic       FetchReq;
   logic       PixOut;
   logic       CssOut;
   logic       Underrun;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [7:0] rom_tbl [64][16];

   // Reference model state: row in cell, latched byte, pending-valid, sticky underrun
   int         m_row;
   logic [6:0] m_latch;
   bit         m_valid;
   bit         m_under;

   alpha_pixel_shifter #(.GLYPH_TOP(3), .CELL_ROWS(12)) dut (
      .Clk(Clk), .nReset(nReset), .PixEn(PixEn), .HActive(HActive),
      .LineStart(LineStart), .FieldStart(FieldStart), .VData(VData),
      .VStrobe(VStrobe), .Css(Css), .RomData(RomData), .CharCode(CharCode),
      .RomRow(RomRow), .FetchReq(FetchReq), .PixOut(PixOut), .CssOut(CssOut),
      .Underrun(Underrun)
   );

   assign RomData = rom_tbl[CharCode][RomRow];

   always #5 Clk = ~Clk;

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit model_in_band();
      return (m_row >= 3) && (m_row <= 9);
   endfunction

   function automatic logic [7:0] model_rom_row();
      return model_in_band() ? 8'(m_row - 3) : 8'h00;
   endfunction

   function automatic logic [7:0] model_glyph();
      logic [7:0] base;
      base = model_in_band() ? rom_tbl[m_latch[5:0]][4'(m_row - 3)] : 8'h00;
      if (!m_valid) return 8'h00;
      return m_latch[6] ? ~base : base;
   endfunction

   task automatic line_start(input bit with_field);
      LineStart  = 1'b1;
      FieldStart = with_field;
      tick;
      LineStart  = 1'b0;
      FieldStart = 1'b0;
      if (with_field) begin
         m_row   = 0;
         m_under = 0;
      end else begin
         m_row = (m_row + 1) % 12;
      end
      check("fetch_after_line", 8'(FetchReq), 8'h01);
      check("rom_row", 8'(RomRow), model_rom_row());
      tick;
      check("fetch_one_clk_line", 8'(FetchReq), 8'h00);
   endtask

   task automatic strobe(input logic [7:0] b);
      VData   = b;
      VStrobe = 1'b1;
      tick;
      VStrobe = 1'b0;
      m_latch = b[6:0];
      m_valid = 1;
      check("char_code", 8'(CharCode), 8'(b[5:0]));
   endtask

   // One 8-pixel cell, optionally with a new byte strobed on the load clock
   task automatic run_cell(input bit collide, input logic [7:0] cb);
      logic [7:0] glyph;
      logic       css_v;
      glyph   = model_glyph();
      if (!m_valid) m_under = 1;
      m_valid = 0;
      css_v   = 1'($urandom);
      Css     = css_v;
      HActive = 1'b1;
      for (int i = 0; i < 8; i++) begin
         PixEn = 1'b1;
         if (i == 0 && collide) begin
            VData   = cb;
            VStrobe = 1'b1;
         end
         tick;
         PixEn   = 1'b0;
         VStrobe = 1'b0;
         check("pix_out", 8'(PixOut), 8'(glyph[7-i]));
         if (i == 0) begin
            check("css_out", 8'(CssOut), 8'(css_v));
            check("fetch_after_load", 8'(FetchReq), 8'h01);
            if (collide) begin
               m_latch = cb[6:0];
               m_valid = 1;
            end
         end
         tick;
         if (i == 0) check("fetch_one_clk_load", 8'(FetchReq), 8'h00);
      end
      HActive = 1'b0;
      PixEn   = 1'b1;
      tick;
      PixEn   = 1'b0;
      check("pix_blank", 8'(PixOut), 8'h00);
      check("underrun", 8'(Underrun), 8'(m_under));
   endtask

   initial begin
      Clk = 1'b0; nReset = 1'b0; PixEn = 1'b0; HActive = 1'b0;
      LineStart = 1'b0; FieldStart = 1'b0; VData = 8'h00; VStrobe = 1'b0; Css = 1'b0;
      m_row = 0; m_latch = '0; m_valid = 0; m_under = 0;
      for (int c = 0; c < 64; c++)
         for (int r = 0; r < 16; r++)
            rom_tbl[c][r] = {1'b0, 5'($urandom), 2'b00};
      rom_tbl[1][0] = 8'h08;

      tick;
      check("rst_pix", 8'(PixOut), 8'h00);
      check("rst_fetch", 8'(FetchReq), 8'h00);
      check("rst_css", 8'(CssOut), 8'h00);
      check("rst_under", 8'(Underrun), 8'h00);
      check("rst_rom_row", 8'(RomRow), 8'h00);
      check("rst_char", 8'(CharCode), 8'h00);
      #2 nReset = 1'b1;

      // Normal glyph at row 3, then its inverse
      line_start(1);
      repeat (3) line_start(0);
      strobe(8'h01);
      run_cell(0, 8'h00);
      strobe(8'h41);
      run_cell(0, 8'h00);

      // Underrun: no strobe before the load, sticky until field start
      run_cell(0, 8'h00);
      line_start(0);
      check("under_hold", 8'(Underrun), 8'h01);
      line_start(1);
      check("under_clear", 8'(Underrun), 8'h00);

      // Out-of-band inverse gives a solid bar
      line_start(0);
      strobe(8'h41);
      run_cell(0, 8'h00);

      // Collision: new byte strobed on the load clock
      line_start(0);
      line_start(0);
      strobe(8'h01);
      run_cell(1, 8'h02);
      run_cell(0, 8'h00);

      // Row wrap and FieldStart priority
      line_start(1);
      repeat (16) line_start(0);
      line_start(1);
      repeat (5) line_start(0);
      line_start(1);
      repeat (4) line_start(0);

      // Asynchronous reset mid-cell
      run_cell(0, 8'h00);
      strobe(8'h41);
      Css = 1'b1;
      HActive = 1'b1;
      for (int i = 0; i < 4; i++) begin
         PixEn = 1'b1;
         tick;
         PixEn = 1'b0;
         tick;
      end
      #2 nReset = 1'b0;
      #1;
      check("arst_pix", 8'(PixOut), 8'h00);
      check("arst_fetch", 8'(FetchReq), 8'h00);
      check("arst_css", 8'(CssOut), 8'h00);
      check("arst_under", 8'(Underrun), 8'h00);
      HActive = 1'b0;
      #3 nReset = 1'b1;
      m_row = 0; m_latch = '0; m_valid = 0; m_under = 0;
      line_start(0);

      // Randomized fields
      for (int f = 0; f < 3; f++) begin
         line_start(1);
         for (int l = 0; l < 14; l++) begin
            line_start(0);
            for (int c = 0; c < 2; c++) begin
               if ($urandom_range(7) != 0) strobe(8'($urandom));
               if ($urandom_range(5) == 0) run_cell(1, 8'($urandom));
               else                        run_cell(0, 8'h00);
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
